// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the doubleword data-memory responder.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DWORD_BYTES = 8;
  localparam int OFS_W       = 3;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
  } req_hdr_t;

  // Misaligned or past the end of the array; checked on the full word index.
  function automatic logic addr_err(input logic [31:0] a, input int depth);
    logic [31:0] idx;
    idx = {{OFS_W{1'b0}}, a[31:OFS_W]};
    return (a[OFS_W-1:0] != '0) || (idx >= 32'(depth));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM: write-enable, registered read data, contents not reset.
module dmem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  // Only the output register is reset; stored words survive reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multicycle ld/sd responder: latches one request, waits WAIT_CYCLES, then acks.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_hdr_t          hdr_q, hdr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rzero_q, rzero_d;

  logic              rd_start;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic              cur_err;
  logic              resp_err;
  logic              arr_we, arr_re;
  logic [IDX_W-1:0]  arr_idx;
  logic [DATA_W-1:0] arr_rdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      wdata_q <= '0;
      rzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      wdata_q <= wdata_d;
      rzero_q <= rzero_d;
    end
  end

  // With zero wait states the read launches off the live inputs at acceptance.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    wdata_d  = wdata_q;
    rd_start = 1'b0;
    cur_we   = hdr_q.we;
    cur_addr = hdr_q.addr;
    case (state_q)
      IDLE: begin
        cur_we   = we;
        cur_addr = addr;
        if (req) begin
          hdr_d   = '{we: we, addr: addr};
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d  = RESP;
            rd_start = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          rd_start = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cur_err  = addr_err(cur_addr, DEPTH);
  assign resp_err = addr_err(hdr_q.addr, DEPTH);

  // rzero_q masks rdata after an erroring load and holds until the next load.
  always_comb begin
    rzero_d = rzero_q;
    if (rd_start && !cur_we) rzero_d = cur_err;
  end

  assign arr_re  = rd_start & ~cur_we & ~cur_err;
  assign arr_we  = (state_q == RESP) & hdr_q.we & ~resp_err;
  assign arr_idx = (state_q == RESP) ? hdr_q.addr[OFS_W +: IDX_W]
                                     : cur_addr[OFS_W +: IDX_W];

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .idx_i   (arr_idx),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  assign rdata = rzero_q ? '0 : arr_rdata;
  assign ack   = (state_q == RESP);
  assign busy  = (state_q != IDLE);
  assign err   = ack & resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) checked by ack monitors.
module tb_dmem_responder;

  typedef struct {
    int          cyc;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  logic        clock = 1'b0;
  int          cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;

  logic        a_rst, a_req, a_we, a_ack, a_busy, a_err;
  logic [31:0] a_addr;
  logic [63:0] a_wdata, a_rdata;
  logic        b_rst, b_req, b_we, b_ack, b_busy, b_err;
  logic [31:0] b_addr;
  logic [63:0] b_wdata, b_rdata;

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;
  logic [63:0] model [256];
  logic [63:0] a_last, b_last;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_responder #(.DATA_W(64), .DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clock(clock), .reset(a_rst), .req(a_req), .we(a_we), .addr(a_addr),
    .wdata(a_wdata), .rdata(a_rdata), .ack(a_ack), .busy(a_busy), .err(a_err)
  );

  dmem_responder #(.DATA_W(64), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .clock(clock), .reset(b_rst), .req(b_req), .we(b_we), .addr(b_addr),
    .wdata(b_wdata), .rdata(b_rdata), .ack(b_ack), .busy(b_busy), .err(b_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (a_ack) begin
      if (qa.size() == 0) chk("a_unexpected_ack", a_ack, 0);
      else begin
        ea = qa.pop_front();
        chk("a_err", a_err, ea.err);
        chk("a_rdata", a_rdata, ea.rdata);
        chk("a_ack_cycle", cyc, ea.cyc);
        chk("a_busy_at_ack", a_busy, 1);
      end
    end else if (qa.size() > 0 && cyc > qa[0].cyc) begin
      chk("a_ack_missing", a_ack, 1);
      void'(qa.pop_front());
    end
  end

  always @(negedge clock) begin
    if (b_ack) begin
      if (qb.size() == 0) chk("b_unexpected_ack", b_ack, 0);
      else begin
        eb = qb.pop_front();
        chk("b_err", b_err, eb.err);
        chk("b_rdata", b_rdata, eb.rdata);
        chk("b_ack_cycle", cyc, eb.cyc);
        chk("b_busy_at_ack", b_busy, 1);
      end
    end else if (qb.size() > 0 && cyc > qb[0].cyc) begin
      chk("b_ack_missing", b_ack, 1);
      void'(qb.pop_front());
    end
  end

  // Called at the negedge where the request is driven (cycle 0 of the transaction).
  task automatic push_a(input logic w, input logic [31:0] ad, input logic [63:0] wd, input logic e_err);
    exp_t e;
    if (!w) a_last = e_err ? 64'd0 : model[ad[10:3]];
    e.cyc = cyc + 3; e.err = e_err; e.rdata = a_last;
    qa.push_back(e);
    if (w && !e_err) model[ad[10:3]] = wd;
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 20; i++) begin
      if (!a_busy) break;
      @(negedge clock);
    end
    chk("a_busy_drop", a_busy, 0);
  endtask

  task automatic issue_a(input logic w, input logic [31:0] ad, input logic [63:0] wd, input logic e_err);
    @(negedge clock);
    a_req = 1'b1; a_we = w; a_addr = ad; a_wdata = wd;
    push_a(w, ad, wd, e_err);
    @(negedge clock);
    // Scramble inputs after acceptance; the transaction must not notice.
    a_req = 1'b0; a_we = ~w; a_addr = 32'h0000_0018; a_wdata = ~wd;
    wait_idle_a();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int k, guard;
    logic        ops_w [4];
    logic [63:0] ops_d [4];

    a_rst = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_rst = 1'b0; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    a_last = '0; b_last = '0;
    repeat (2) @(negedge clock);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_b_busy", b_busy, 0);
    a_rst = 1'b1; b_rst = 1'b1;

    // Preload words used by later boundary checks.
    issue_a(1'b1, 32'h0000_0000, 64'h0123_4567_89AB_CDEF, 1'b0);
    issue_a(1'b1, 32'h0000_0008, 64'h1111_2222_3333_4444, 1'b0);
    issue_a(1'b1, 32'h0000_07F8, 64'hA5A5_5A5A_F0F0_0F0F, 1'b0);
    issue_a(1'b1, 32'h0000_0030, 64'h3030_3030_3030_3030, 1'b0);
    issue_a(1'b1, 32'h0000_0048, 64'h4848_0000_4848_0000, 1'b0);

    // Store then load.
    issue_a(1'b1, 32'h0000_0010, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    issue_a(1'b0, 32'h0000_0010, 64'h0, 1'b0);

    // Misaligned.
    issue_a(1'b0, 32'h0000_0013, 64'h0, 1'b1);
    issue_a(1'b1, 32'h0000_000C, 64'h5555_6666_7777_8888, 1'b1);
    issue_a(1'b0, 32'h0000_0008, 64'h0, 1'b0);

    // Out of range; 0x800 would alias word 0 if truncated before the check.
    issue_a(1'b1, 32'h0000_0800, 64'hBAD0_BAD0_BAD0_BAD0, 1'b1);
    issue_a(1'b0, 32'h0000_0800, 64'h0, 1'b1);
    issue_a(1'b0, 32'h0000_0000, 64'h0, 1'b0);
    issue_a(1'b0, 32'h0000_07F8, 64'h0, 1'b0);

    // Second request during WAIT must be ignored.
    @(negedge clock);
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h0000_0040; a_wdata = 64'h4040_4040_0000_0001;
    push_a(1'b1, 32'h0000_0040, 64'h4040_4040_0000_0001, 1'b0);
    @(negedge clock);
    a_we = 1'b1; a_addr = 32'h0000_0048; a_wdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clock);
    chk("a_busy_in_wait", a_busy, 1);
    a_req = 1'b0;
    wait_idle_a();
    issue_a(1'b0, 32'h0000_0040, 64'h0, 1'b0);
    issue_a(1'b0, 32'h0000_0048, 64'h0, 1'b0);

    // Reset during WAIT drops the store.
    @(negedge clock);
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h0000_0030; a_wdata = 64'h9999_9999_9999_9999;
    @(negedge clock);
    a_req = 1'b0; a_rst = 1'b0;
    #1;
    chk("a_midrst_ack", a_ack, 0);
    chk("a_midrst_busy", a_busy, 0);
    chk("a_midrst_rdata", a_rdata, 0);
    @(negedge clock);
    a_rst = 1'b1; a_last = '0;
    issue_a(1'b0, 32'h0000_0030, 64'h0, 1'b0);

    // Zero wait states, req held high, alternating sd/ld at 0x20.
    ops_w[0] = 1'b1; ops_d[0] = 64'h2020_AAAA_2020_AAAA;
    ops_w[1] = 1'b0; ops_d[1] = 64'h0;
    ops_w[2] = 1'b1; ops_d[2] = 64'h2020_5555_2020_5555;
    ops_w[3] = 1'b0; ops_d[3] = 64'h0;
    k = 0; guard = 0;
    while (k < 4 && guard < 40) begin
      @(negedge clock);
      guard++;
      if (!b_busy) begin
        b_req = 1'b1; b_we = ops_w[k]; b_addr = 32'h0000_0020; b_wdata = ops_d[k];
        if (ops_w[k]) model[4] = ops_d[k];
        else b_last = model[4];
        eb.cyc = cyc + 1; eb.err = 1'b0; eb.rdata = b_last;
        qb.push_back(eb);
        k++;
      end
    end
    chk("b_ops_issued", k, 4);
    @(negedge clock);
    b_req = 1'b0;
    repeat (4) @(negedge clock);
    chk("b_busy_idle", b_busy, 0);

    repeat (4) @(negedge clock);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
